iir_mac_sequencer: RTL

//   Sequences one time-multiplexed IIR section: per input sample, walks the coefficient

---
 rtl/iir_mac_sequencer_if.sv | 34 +++
 rtl/iir_mac_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/iir_mac_sequencer_if.sv
// Control bundle between the IIR section sequencer and its coefficient mux, delay lines and MAC.
// The master side raises sample/update requests; the slave side (the sequencer) drives control.
interface iir_mac_sequencer_if #(
   parameter int SEL_W = 2
);
   logic             ic_val_sample;
   logic             ic_upd_a;
   logic             ic_upd_b;
   logic             oc_val_coef_a;
   logic             oc_val_coef_b;
   logic [SEL_W-1:0] oc_coef_sel;
   logic             oc_sel_a_b;
   logic [SEL_W-1:0] oc_tap_sel;
   logic             oc_tap_a_b;
   logic             oc_mac_en;
   logic             oc_mac_clr;
   logic             oc_shift;
   logic             oc_val_out;
   logic             oc_busy;
   logic             oc_upd_pend;
   logic             oc_overrun;

   modport master (
      output ic_val_sample, ic_upd_a, ic_upd_b,
      input  oc_val_coef_a, oc_val_coef_b, oc_coef_sel, oc_sel_a_b, oc_tap_sel, oc_tap_a_b,
      input  oc_mac_en, oc_mac_clr, oc_shift, oc_val_out, oc_busy, oc_upd_pend, oc_overrun
   );

   modport slave (
      input  ic_val_sample, ic_upd_a, ic_upd_b,
      output oc_val_coef_a, oc_val_coef_b, oc_coef_sel, oc_sel_a_b, oc_tap_sel, oc_tap_a_b,
      output oc_mac_en, oc_mac_clr, oc_shift, oc_val_out, oc_busy, oc_upd_pend, oc_overrun
   );
endinterface

// File: rtl/iir_mac_sequencer.sv
// Sequences one time-multiplexed IIR section: b0..bN then a1..aN through the coefficient mux,
// MAC/tap control one cycle behind, and coefficient-bank loads held off until the section is idle.
module iir_mac_sequencer #(
   parameter int ORDER_IIR = 2,
   parameter int SEL_W     = $clog2(ORDER_IIR + 1)
) (
   input logic              ic_clk,
   input logic              ic_rst_n,
   iir_mac_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RUN_B, RUN_A, DRAIN, DONE} state_t;

   localparam logic [SEL_W-1:0] K_B_LAST = SEL_W'(ORDER_IIR);
   localparam logic [SEL_W-1:0] K_A_LAST = SEL_W'(ORDER_IIR - 1);

   state_t           state;
   logic [SEL_W-1:0] k;
   logic             pend_a;
   logic             pend_b;
   logic             load_ok;
   logic             ld_a;
   logic             ld_b;
   logic             pend_a_n;
   logic             pend_b_n;

   // Loads are decided in DONE so the strobe lands in the first IDLE cycle; in IDLE a sample wins.
   always_comb begin
      load_ok  = (state == DONE) || (state == IDLE && !bus.ic_val_sample);
      ld_a     = load_ok && pend_a;
      ld_b     = load_ok && pend_b;
      pend_a_n = (pend_a && !ld_a) || bus.ic_upd_a;
      pend_b_n = (pend_b && !ld_b) || bus.ic_upd_b;
   end

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state             <= IDLE;
         k                 <= '0;
         pend_a            <= 1'b0;
         pend_b            <= 1'b0;
         bus.oc_val_coef_a <= 1'b0;
         bus.oc_val_coef_b <= 1'b0;
         bus.oc_coef_sel   <= '0;
         bus.oc_sel_a_b    <= 1'b0;
         bus.oc_tap_sel    <= '0;
         bus.oc_tap_a_b    <= 1'b0;
         bus.oc_mac_en     <= 1'b0;
         bus.oc_mac_clr    <= 1'b0;
         bus.oc_shift      <= 1'b0;
         bus.oc_val_out    <= 1'b0;
         bus.oc_busy       <= 1'b0;
         bus.oc_upd_pend   <= 1'b0;
         bus.oc_overrun    <= 1'b0;
      end else begin
         pend_a            <= pend_a_n;
         pend_b            <= pend_b_n;
         bus.oc_val_coef_a <= ld_a;
         bus.oc_val_coef_b <= ld_b;
         bus.oc_upd_pend   <= pend_a_n || pend_b_n || ld_a || ld_b;
         bus.oc_overrun    <= bus.ic_val_sample && (state != IDLE);
         // Tap/MAC path replays the select issued one cycle earlier, matching the mux register.
         bus.oc_mac_en     <= (state == RUN_B) || (state == RUN_A);
         bus.oc_mac_clr    <= (state == RUN_B) && (k == '0);
         bus.oc_tap_sel    <= bus.oc_coef_sel;
         bus.oc_tap_a_b    <= bus.oc_sel_a_b;
         bus.oc_val_out    <= 1'b0;
         bus.oc_shift      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ic_val_sample) begin
                  state           <= RUN_B;
                  k               <= '0;
                  bus.oc_coef_sel <= '0;
                  bus.oc_sel_a_b  <= 1'b0;
                  bus.oc_busy     <= 1'b1;
               end
            end
            RUN_B: begin
               if (k == K_B_LAST) begin
                  state           <= RUN_A;
                  k               <= '0;
                  bus.oc_coef_sel <= '0;
                  bus.oc_sel_a_b  <= 1'b1;
               end else begin
                  k               <= k + 1'b1;
                  bus.oc_coef_sel <= k + 1'b1;
               end
            end
            RUN_A: begin
               if (k == K_A_LAST) begin
                  state           <= DRAIN;
                  k               <= '0;
                  bus.oc_coef_sel <= '0;
                  bus.oc_sel_a_b  <= 1'b0;
               end else begin
                  k               <= k + 1'b1;
                  bus.oc_coef_sel <= k + 1'b1;
               end
            end
            DRAIN: begin
               state          <= DONE;
               bus.oc_val_out <= 1'b1;
               bus.oc_shift   <= 1'b1;
            end
            DONE: begin
               state       <= IDLE;
               bus.oc_busy <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               k           <= '0;
               bus.oc_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
